// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store-unit AXI4-Lite master.
//   size_e        - access size encoding as presented by the core (11 is illegal)
//   state_e       - bus-master FSM states
//   RESP_*        - AXI response codes
//   size_addr_ok  - legality/alignment check for a (size, addr[1:0]) pair
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD,
    RD_R,
    RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // True when the size code is legal and the address is naturally aligned for it.
  function automatic logic size_addr_ok(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (off[0] == 1'b0);
      SZ_WORD: ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_axi_master_lane_align.sv
// lsu_lane_align: purely combinational byte-lane steering for a 32-bit bus.
//   Store side: st_size/st_off/st_wdata -> st_wstrb (byte enables) and
//               st_wdata_lane (right-aligned data replicated across lanes).
//   Load side:  ld_size/ld_off/ld_unsigned/ld_rdata -> ld_result, the addressed
//               byte/half moved to bit 0 and sign- or zero-extended.
// Illegal size codes produce a zero strobe and pass data through unchanged.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  output logic [31:0] st_wdata_lane,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_result
);

  always_comb begin
    st_wstrb      = 4'b0000;
    st_wdata_lane = st_wdata;
    case (st_size)
      SZ_BYTE: begin
        st_wstrb      = 4'b0001 << st_off;
        st_wdata_lane = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_wstrb      = 4'b0011 << st_off;
        st_wdata_lane = {2{st_wdata[15:0]}};
      end
      SZ_WORD: begin
        st_wstrb      = 4'b1111;
        st_wdata_lane = st_wdata;
      end
      default: begin
        st_wstrb      = 4'b0000;
        st_wdata_lane = st_wdata;
      end
    endcase
  end

  logic [31:0] shifted;
  logic        sign_bit;

  always_comb begin
    shifted   = ld_rdata >> {ld_off, 3'b000};
    sign_bit  = 1'b0;
    ld_result = ld_rdata;
    case (ld_size)
      SZ_BYTE: begin
        sign_bit  = shifted[7] & ~ld_unsigned;
        ld_result = {{24{sign_bit}}, shifted[7:0]};
      end
      SZ_HALF: begin
        sign_bit  = shifted[15] & ~ld_unsigned;
        ld_result = {{16{sign_bit}}, shifted[15:0]};
      end
      default: ld_result = ld_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_axi_master.sv
// lsu_axi_master: AXI4-Lite master for the RV32I load/store unit.
//   Core side:  req_valid/req_ready handshake with req_we, req_size, req_unsigned,
//               req_addr, req_wdata; completion is a one-cycle resp_valid pulse with
//               resp_rdata (extended load data, 0 for stores/errors) and resp_err.
//   AXI side:   AW/W/B write channels and AR/R read channels, one outstanding
//               transaction. BREADY/RREADY stay high across the whole transaction
//               because the slave only pulses its VALIDs for one cycle.
//   Misaligned or illegal-size requests complete with an error without touching
//   the bus. Any bus-wait state that lasts TIMEOUT_CYCLES cycles is abandoned
//   with an error.
module lsu_axi_master
  import lsu_pkg::*;
#(
  parameter int AXI_AWIDTH     = 32,
  parameter int AXI_DWIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    AXI_ACLK,
  input  logic                    AXI_ARESET,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    resp_valid,
  output logic [31:0]             resp_rdata,
  output logic                    resp_err,
  output logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
  output logic                    AXI_AWVALID,
  input  logic                    AXI_AWREADY,
  output logic [AXI_DWIDTH-1:0]   AXI_WDATA,
  output logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
  output logic                    AXI_WVALID,
  input  logic                    AXI_WREADY,
  input  logic [1:0]              AXI_BRESP,
  input  logic                    AXI_BVALID,
  output logic                    AXI_BREADY,
  output logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
  output logic                    AXI_ARVALID,
  input  logic                    AXI_ARREADY,
  input  logic [AXI_DWIDTH-1:0]   AXI_RDATA,
  input  logic [1:0]              AXI_RRESP,
  input  logic                    AXI_RVALID,
  output logic                    AXI_RREADY
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // The timeout fires while the counter shows the last permitted cycle, so the
  // state is left exactly TIMEOUT_CYCLES cycles after entry.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e         state_reg, state_next;
  logic           aw_done_reg, aw_done_next;
  logic           w_done_reg, w_done_next;
  logic [TW-1:0]  timer_reg, timer_next;
  logic           err_reg, err_next;
  logic [31:0]    rdata_reg, rdata_next;

  logic [31:0]    addr_reg;
  logic [1:0]     size_reg;
  logic           unsigned_reg;
  logic [3:0]     wstrb_reg;
  logic [31:0]    wdata_reg;

  logic [3:0]     st_wstrb;
  logic [31:0]    st_wdata_lane;
  logic [31:0]    ld_result;
  logic           accept;
  logic           timeout;

  lsu_lane_align u_lane_align (
    .st_size       (req_size),
    .st_off        (req_addr[1:0]),
    .st_wdata      (req_wdata),
    .st_wstrb      (st_wstrb),
    .st_wdata_lane (st_wdata_lane),
    .ld_size       (size_reg),
    .ld_off        (addr_reg[1:0]),
    .ld_unsigned   (unsigned_reg),
    .ld_rdata      (AXI_RDATA),
    .ld_result     (ld_result)
  );

  assign accept  = (state_reg == IDLE) && req_valid;
  assign timeout = (timer_reg == TMO_LAST);

  // Request fields are captured once so bus address/data stay stable under VALID.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      addr_reg     <= '0;
      size_reg     <= '0;
      unsigned_reg <= 1'b0;
      wstrb_reg    <= '0;
      wdata_reg    <= '0;
    end else if (accept) begin
      addr_reg     <= req_addr;
      size_reg     <= req_size;
      unsigned_reg <= req_unsigned;
      wstrb_reg    <= st_wstrb;
      wdata_reg    <= st_wdata_lane;
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      state_reg   <= IDLE;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      timer_reg   <= '0;
      err_reg     <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      aw_done_reg <= aw_done_next;
      w_done_reg  <= w_done_next;
      timer_reg   <= timer_next;
      err_reg     <= err_next;
      rdata_reg   <= rdata_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    aw_done_next = aw_done_reg;
    w_done_next  = w_done_reg;
    timer_next   = timer_reg;
    err_next     = err_reg;
    rdata_next   = rdata_reg;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    AXI_AWVALID  = 1'b0;
    AXI_WVALID   = 1'b0;
    AXI_BREADY   = 1'b0;
    AXI_ARVALID  = 1'b0;
    AXI_RREADY   = 1'b0;

    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          timer_next   = '0;
          err_next     = 1'b0;
          rdata_next   = '0;
          if (!size_addr_ok(req_size, req_addr[1:0])) begin
            err_next   = 1'b1;
            state_next = RESP;
          end else if (req_we) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end

      WR: begin
        AXI_AWVALID  = !aw_done_reg;
        AXI_WVALID   = !w_done_reg;
        AXI_BREADY   = 1'b1;
        timer_next   = timer_reg + TW'(1);
        aw_done_next = aw_done_reg | AXI_AWREADY;
        w_done_next  = w_done_reg | AXI_WREADY;
        if (aw_done_next && w_done_next) begin
          // The slave may return B in the same cycle as the last address/data beat.
          if (AXI_BVALID) begin
            err_next   = (AXI_BRESP != RESP_OKAY);
            state_next = RESP;
          end else begin
            timer_next = '0;
            state_next = WR_B;
          end
        end else if (timeout) begin
          err_next   = 1'b1;
          state_next = RESP;
        end
      end

      WR_B: begin
        AXI_BREADY = 1'b1;
        timer_next = timer_reg + TW'(1);
        if (AXI_BVALID) begin
          err_next   = (AXI_BRESP != RESP_OKAY);
          state_next = RESP;
        end else if (timeout) begin
          err_next   = 1'b1;
          state_next = RESP;
        end
      end

      RD: begin
        AXI_ARVALID = 1'b1;
        AXI_RREADY  = 1'b1;
        timer_next  = timer_reg + TW'(1);
        if (AXI_ARREADY) begin
          if (AXI_RVALID) begin
            err_next   = (AXI_RRESP != RESP_OKAY);
            rdata_next = (AXI_RRESP != RESP_OKAY) ? 32'd0 : ld_result;
            state_next = RESP;
          end else begin
            timer_next = '0;
            state_next = RD_R;
          end
        end else if (timeout) begin
          err_next   = 1'b1;
          rdata_next = '0;
          state_next = RESP;
        end
      end

      RD_R: begin
        AXI_RREADY = 1'b1;
        timer_next = timer_reg + TW'(1);
        if (AXI_RVALID) begin
          err_next   = (AXI_RRESP != RESP_OKAY);
          rdata_next = (AXI_RRESP != RESP_OKAY) ? 32'd0 : ld_result;
          state_next = RESP;
        end else if (timeout) begin
          err_next   = 1'b1;
          rdata_next = '0;
          state_next = RESP;
        end
      end

      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // Response payload is only presented during the completion pulse.
  assign resp_err   = (state_reg == RESP) && err_reg;
  assign resp_rdata = (state_reg == RESP) ? rdata_reg : 32'd0;

  assign AXI_AWADDR = addr_reg[AXI_AWIDTH-1:0];
  assign AXI_ARADDR = addr_reg[AXI_AWIDTH-1:0];
  assign AXI_WDATA  = wdata_reg;
  assign AXI_WSTRB  = wstrb_reg;

endmodule

// File: tb/tb_lsu_axi_master.sv
// tb_lsu_axi_master: scoreboard bench for lsu_axi_master with a behavioural
// AXI4-Lite memory slave (16 words) whose behaviour is selected per test:
// immediate responses, a hung AR channel, a withheld B response, or SLVERR on B.
module tb_lsu_axi_master;
  import lsu_pkg::*;

  localparam int TMO = 8;
  localparam int M_NORM   = 0;
  localparam int M_ARHANG = 1;
  localparam int M_BHOLD  = 2;
  localparam int M_BERR   = 3;

  logic        AXI_ACLK = 1'b0;
  logic        AXI_ARESET;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] AXI_AWADDR, AXI_WDATA, AXI_ARADDR, AXI_RDATA;
  logic        AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY;
  logic [3:0]  AXI_WSTRB;
  logic [1:0]  AXI_BRESP, AXI_RRESP;
  logic        AXI_BVALID, AXI_BREADY, AXI_ARVALID, AXI_ARREADY, AXI_RVALID, AXI_RREADY;

  always #5 AXI_ACLK = ~AXI_ACLK;

  lsu_axi_master #(.AXI_AWIDTH(32), .AXI_DWIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .AXI_ACLK(AXI_ACLK), .AXI_ARESET(AXI_ARESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
    .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
    .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int          mode = M_NORM;
  logic [31:0] mem [16];
  logic [31:0] last_awaddr, last_wdata;
  logic [3:0]  last_wstrb;

  always_comb begin
    AXI_AWREADY = AXI_AWVALID;
    AXI_WREADY  = AXI_WVALID;
    AXI_BVALID  = (mode != M_BHOLD) && AXI_AWVALID && AXI_WVALID;
    AXI_BRESP   = (mode == M_BERR) ? RESP_SLVERR : RESP_OKAY;
    AXI_ARREADY = (mode != M_ARHANG) && AXI_ARVALID;
    AXI_RVALID  = AXI_ARREADY;
    AXI_RDATA   = mem[AXI_ARADDR[5:2]];
    AXI_RRESP   = RESP_OKAY;
  end

  always @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      last_awaddr <= 32'd0;
      last_wdata  <= 32'd0;
      last_wstrb  <= 4'd0;
    end else if (AXI_AWVALID && AXI_AWREADY && AXI_WVALID && AXI_WREADY) begin
      for (int b = 0; b < 4; b++)
        if (AXI_WSTRB[b]) mem[AXI_AWADDR[5:2]][8*b +: 8] <= AXI_WDATA[8*b +: 8];
      last_awaddr <= AXI_AWADDR;
      last_wdata  <= AXI_WDATA;
      last_wstrb  <= AXI_WSTRB;
    end
  end

  // ---------------- monitors / scoreboard ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int cyc = 0;
  int accept_cyc = 0;
  int resp_cnt = 0;
  int act_cnt = 0;
  int ar_cnt = 0;

  always @(posedge AXI_ACLK) begin
    cyc <= cyc + 1;
    if (!AXI_ARESET && (AXI_AWVALID || AXI_WVALID || AXI_ARVALID)) act_cnt <= act_cnt + 1;
    if (!AXI_ARESET && AXI_ARVALID) ar_cnt <= ar_cnt + 1;
  end

  always @(negedge AXI_ACLK) begin
    exp_t e;
    if (!AXI_ARESET && resp_valid) begin
      resp_cnt <= resp_cnt + 1;
      $display("resp #%0d rdata=0x%08h err=%0b lat=%0d", resp_cnt, resp_rdata, resp_err,
               cyc - accept_cyc + 1);
      if (sb_q.size() == 0) begin
        check_val("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("resp_rdata", resp_rdata, e.rdata);
        check_val("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        check_val("resp_latency", cyc - accept_cyc + 1, e.lat);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    exp_t e;
    int target;
    int n;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    @(negedge AXI_ACLK);
    target       = resp_cnt + 1;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge AXI_ACLK);
      n++;
    end
    if (!req_ready) check_val("accept_timeout", 32'd0, 32'd1);
    sb_q.push_back(e);
    accept_cyc = cyc + 1;
    @(negedge AXI_ACLK);
    req_valid = 1'b0;
    n = 0;
    while (resp_cnt < target && n < 100) begin
      @(negedge AXI_ACLK);
      n++;
    end
    if (resp_cnt < target) check_val("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_ctl"},
              {24'd0, req_ready, resp_valid, resp_err, AXI_AWVALID, AXI_WVALID,
               AXI_BREADY, AXI_ARVALID, AXI_RREADY}, 32'h80);
    check_val({tag, "_rdata"}, resp_rdata, 32'd0);
    check_val({tag, "_awaddr"}, AXI_AWADDR, 32'd0);
    check_val({tag, "_wstrb"}, {28'd0, AXI_WSTRB}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0;
    AXI_ARESET   = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;
    repeat (3) @(negedge AXI_ACLK);
    check_idle_outputs("reset");
    AXI_ARESET = 1'b0;

    // Word store then readback.
    do_req(1'b1, SZ_WORD, 1'b0, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    check_val("sw_wstrb", {28'd0, last_wstrb}, 32'hF);
    check_val("sw_wdata", last_wdata, 32'hDEADBEEF);
    check_val("sw_awaddr", last_awaddr, 32'h8);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Byte store into the top lane, signed and unsigned byte loads.
    do_req(1'b1, SZ_BYTE, 1'b0, 32'hB, 32'h123456A5, 32'h0, 1'b0, 2);
    check_val("sb_wstrb", {28'd0, last_wstrb}, 32'h8);
    check_val("sb_wdata", last_wdata, 32'hA5A5A5A5);
    check_val("sb_awaddr", last_awaddr, 32'hB);
    do_req(1'b0, SZ_BYTE, 1'b0, 32'hB, 32'h0, 32'hFFFFFFA5, 1'b0, 2);
    do_req(1'b0, SZ_BYTE, 1'b1, 32'hB, 32'h0, 32'h000000A5, 1'b0, 2);

    // Half loads from word 0x80017FFF at 0x4.
    do_req(1'b1, SZ_WORD, 1'b0, 32'h4, 32'h80017FFF, 32'h0, 1'b0, 2);
    do_req(1'b0, SZ_HALF, 1'b0, 32'h6, 32'h0, 32'hFFFF8001, 1'b0, 2);
    do_req(1'b0, SZ_HALF, 1'b1, 32'h4, 32'h0, 32'h00007FFF, 1'b0, 2);
    do_req(1'b0, SZ_HALF, 1'b0, 32'h4, 32'h0, 32'h00007FFF, 1'b0, 2);
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h5, 32'h0, 32'h0000007F, 1'b0, 2);
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h4, 32'h0, 32'hFFFFFFFF, 1'b0, 2);

    // Half store into the upper lanes.
    do_req(1'b1, SZ_HALF, 1'b0, 32'h6, 32'hBEEF1234, 32'h0, 1'b0, 2);
    check_val("sh_wstrb", {28'd0, last_wstrb}, 32'hC);
    check_val("sh_wdata", last_wdata, 32'h12341234);
    do_req(1'b0, SZ_HALF, 1'b1, 32'h6, 32'h0, 32'h00001234, 1'b0, 2);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 32'h12347FFF, 1'b0, 2);

    // Error path: no bus activity, response one cycle after acceptance.
    a0 = act_cnt;
    do_req(1'b0, SZ_WORD, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1, 1);
    do_req(1'b0, 2'b11,   1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1);
    do_req(1'b1, SZ_HALF, 1'b0, 32'h5, 32'hFFFF, 32'h0, 1'b1, 1);
    do_req(1'b1, SZ_WORD, 1'b0, 32'h9, 32'hFFFF, 32'h0, 1'b1, 1);
    check_val("err_no_axi", act_cnt - a0, 32'd0);

    // AR channel never answers: abandon after TMO cycles.
    mode = M_ARHANG;
    a0 = ar_cnt;
    do_req(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 32'h0, 1'b1, TMO + 1);
    check_val("tmo_arvalid_cycles", ar_cnt - a0, TMO);
    check_val("tmo_arvalid_low", {31'd0, AXI_ARVALID}, 32'd0);
    mode = M_NORM;
    do_req(1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 32'hA5ADBEEF, 1'b0, 2);

    // Reset while waiting for B.
    mode = M_BHOLD;
    @(negedge AXI_ACLK);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = SZ_WORD;
    req_addr  = 32'hC;
    req_wdata = 32'h55AA55AA;
    check_val("bhold_ready", {31'd0, req_ready}, 32'd1);
    @(negedge AXI_ACLK);
    req_valid = 1'b0;
    repeat (2) @(negedge AXI_ACLK);
    check_val("bhold_wait_b", {30'd0, AXI_BREADY, AXI_AWVALID | AXI_WVALID}, 32'h2);
    AXI_ARESET = 1'b1;
    @(negedge AXI_ACLK);
    check_idle_outputs("midreset");
    AXI_ARESET = 1'b0;

    // SLVERR on B, then confirm normal operation resumes.
    mode = M_BERR;
    do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h13572468, 32'h0, 1'b1, 2);
    mode = M_NORM;
    do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h13572468, 1'b0, 2);

    repeat (3) @(negedge AXI_ACLK);
    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
AXI4-Lite master bridging the RV32I core's load/store unit to the data-memory slave. Accepts one core load/store request at a time and checks alignment. Builds WSTRB and lane-replicated WDATA for stores, runs the AXI-Lite write or read transaction, and returns sign- or zero-extended load data. Sits directly upstream of the memory slave; all slave handshakes are one-cycle pulses, so the master holds READY signals high for the whole transaction.

Parameters:
AXI_AWIDTH, 32, AXI address width; the low AXI_AWIDTH bits of req_addr are driven onto the bus.
AXI_DWIDTH, 32, AXI data width; fixed 32 for RV32I.
TIMEOUT_CYCLES, 255, maximum cycles spent in any bus-wait state before an error response is returned.

Ports:
AXI_ACLK  in  1  clock
AXI_ARESET  in  1  synchronous active-high reset
req_valid  in  1  core request strobe
req_ready  out  1  high only in IDLE
req_we  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
req_unsigned  in  1  load zero-extend (LBU/LHU)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, illegal size, nonzero BRESP/RRESP, or timeout
AXI_AWADDR/AWVALID/AWREADY, AXI_WDATA/WSTRB/WVALID/WREADY, AXI_BRESP/BVALID/BREADY, AXI_ARADDR/ARVALID/ARREADY, AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master directions and widths. WSTRB width is AXI_DWIDTH/8.

Behaviour:
- Reset, synchronous and active-high, overrides everything including mid-transaction. All VALIDs and READYs go to 0, resp_valid=0, resp_err=0, resp_rdata=0, state=IDLE, timeout counter=0.
- Request acceptance: a request is accepted when req_valid && req_ready. Address, size, unsigned flag, computed strobe and computed data are registered at acceptance.
- Alignment check: half requires addr[0]=0; word requires addr[1:0]=00. Size 11 is illegal.
- Error path: on misalignment or illegal size, go to RESP with resp_err=1. No AXI activity occurs.
- Store lanes, with off = addr[1:0]:
  - byte: WSTRB=4'b0001<<off, WDATA={4{wdata[7:0]}}.
  - half: WSTRB=4'b0011<<off, WDATA={2{wdata[15:0]}}.
  - word: WSTRB=4'b1111, WDATA=wdata.
- AWADDR and ARADDR carry the full unmodified address.
- State machine:
  - IDLE: accept a request, then go to WR, RD or RESP (error).
  - WR: AWVALID and WVALID are each high until their own READY is seen. Track aw_done and w_done separately. BREADY=1 throughout WR and WR_B. If BVALID arrives in the same cycle as the last READY, go directly to RESP. Otherwise go to WR_B once both are done.
  - WR_B: wait for BVALID, then go to RESP with err=(BRESP!=00).
  - RD: ARVALID=1 and RREADY=1. ARVALID drops the cycle after ARREADY. If RVALID arrives together with ARREADY, go directly to RESP. Otherwise go to RD_R.
  - RD_R: RREADY=1; wait for RVALID, capture data, then go to RESP with err=(RRESP!=00).
  - RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in this cycle, so back-to-back requests have a minimum gap of one cycle.
- Load extraction: shifted = RDATA >> (8*off).
  - byte: result = {{24{s}}, shifted[7:0]}, where s = shifted[7] & ~req_unsigned.
  - half: same rule using shifted[15:0].
  - word: unchanged.
- Timeout: a counter clears on entry to WR, WR_B, RD or RD_R and increments each cycle spent in them. On reaching TIMEOUT_CYCLES:
  - deassert all VALIDs;
  - go to RESP with resp_err=1 and rdata=0.
- Latency against a slave that responds on the first valid cycle:
  - store: accept, then WR (slave asserts AWREADY/WREADY/BVALID together), then RESP → resp_valid 2 cycles after acceptance;
  - load: same timing;
  - misaligned: 1 cycle after acceptance.
- VALID stability: VALIDs never drop before their handshake, except on timeout or reset. Address and data are stable while VALID is high.

Decomposition:
- Package lsu_pkg holds:
  - the size enum (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the state enum (IDLE, WR, WR_B, RD, RD_R, RESP);
  - the AXI response constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10).
- One combinational sub-module, lsu_lane_align, computes WSTRB/WDATA and the load extraction/extension from size, off and unsigned flag. It is unit-testable on its own.

Test Plan:
- Store word 0xDEADBEEF to 0x8 → WSTRB=1111, WDATA=0xDEADBEEF, AWADDR=0x8; resp_valid 2 cycles after acceptance with err=0; a readback load gives 0xDEADBEEF.
- Store byte 0xA5 to 0xB, then load byte and load byte-unsigned from 0xB → WSTRB=1000, WDATA=0xA5A5A5A5; LB returns 0xFFFFFFA5, LBU returns 0x000000A5.
- Load half from 0x6 with memory word 0x80017FFF → LH returns 0xFFFF8001; load half from 0x4 with LHU returns 0x00007FFF.
- Misaligned word load at 0x2, and a size=11 request → no AXI VALID ever asserted; resp_valid with err=1 one cycle after acceptance.
- Slave stub that never asserts ARREADY, TIMEOUT_CYCLES=8 → ARVALID drops after 8 cycles; resp_err=1, resp_rdata=0; next request is accepted normally.
- Assert reset during WR_B, then slave stub with BRESP=10 → reset returns all outputs to 0 and state to IDLE; a subsequent store completes with resp_err=1.
